// File: rtl/pipeline_control_if.sv
// pipeline_control_if: hazard inputs and per-latch enable/flush outputs of the pipeline controller.
interface pipeline_control_if #(parameter int CNT_W = 32);
  logic [4:0] id_rsel1, id_rsel2, ex_rd;
  logic ex_load, ex_muldiv, ex_redirect, imem_ready, dmem_req, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic md_done;
  logic [CNT_W-1:0] stall_cycles;
  modport master(
    input id_rsel1, id_rsel2, ex_rd, ex_load, ex_muldiv, ex_redirect, imem_ready, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output md_done, stall_cycles
  );
  modport slave(
    output id_rsel1, id_rsel2, ex_rd, ex_load, ex_muldiv, ex_redirect, imem_ready, dmem_req, dmem_ready,
    input pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input md_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_control.sv
// pipeline_control: 5-stage pipeline hazard controller producing latch enables/flushes and a stall-cycle counter.
module pipeline_control #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_control_if.master p
);
  localparam int MW = $clog2(MD_CYCLES) + 1;
  typedef enum logic [1:0] {RUN, MD_WAIT, REDIRECT} state_t;
  state_t state, state_n;
  logic [MW-1:0] md_cnt, md_cnt_n;
  logic [CNT_W-1:0] stall_cycles;
  logic [4:0] en;
  logic [3:0] fl;
  logic md_done, dmem_stall, load_use;
  assign dmem_stall = p.dmem_req && !p.dmem_ready;
  assign load_use = p.ex_load && p.ex_rd != 5'd0 && (p.ex_rd == p.id_rsel1 || p.ex_rd == p.id_rsel2);
  // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}; branches follow event priority
  always_comb begin
    en = 5'b11111;
    fl = 4'b0000;
    md_done = 1'b0;
    state_n = state;
    md_cnt_n = md_cnt;
    if (rst) begin
      en = 5'b00000;
      fl = 4'b1111;
      state_n = RUN;
      md_cnt_n = '0;
    end else if (dmem_stall) begin
      en = 5'b00001;
      fl = 4'b0001;
    end else if (state == MD_WAIT && md_cnt == '0) begin
      md_done = 1'b1;
      state_n = RUN;
    end else if (state == MD_WAIT || (state == RUN && p.ex_muldiv)) begin
      en = 5'b00011;
      fl = 4'b0010;
      state_n = MD_WAIT;
      md_cnt_n = state == RUN ? MW'(MD_CYCLES - 1) : md_cnt - 1'b1;
    end else if (state == REDIRECT) begin
      en = 5'b01111;
      fl = 4'b1000;
      state_n = p.imem_ready ? RUN : REDIRECT;
    end else if (p.ex_redirect) begin
      fl = 4'b1100;
      state_n = p.imem_ready ? RUN : REDIRECT;
    end else if (load_use) begin
      en = 5'b00111;
      fl = 4'b0100;
    end else if (!p.imem_ready) begin
      en = 5'b01111;
      fl = 4'b1000;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      md_cnt <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_n;
      md_cnt <= md_cnt_n;
      if (!en[4]) stall_cycles <= stall_cycles + 1'b1;
    end
  end
  assign {p.pc_en, p.ifid_en, p.idex_en, p.exmem_en, p.memwb_en} = en;
  assign {p.ifid_flush, p.idex_flush, p.exmem_flush, p.memwb_flush} = fl;
  assign p.md_done = md_done;
  assign p.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: scoreboard bench; each driven cycle queues its expected control vector and stall count.
module tb_pipeline_control;
  localparam int CNT_W = 32;
  // vector = {pc,ifid,idex,exmem,memwb en ; ifid,idex,exmem,memwb flush ; md_done}
  localparam logic [9:0] DEF = 10'b11111_0000_0;
  localparam logic [9:0] RST = 10'b00000_1111_0;
  localparam logic [9:0] LU  = 10'b00111_0100_0;
  localparam logic [9:0] MDS = 10'b00011_0010_0;
  localparam logic [9:0] MDD = 10'b11111_0000_1;
  localparam logic [9:0] DMS = 10'b00001_0001_0;
  localparam logic [9:0] RDR = 10'b11111_1100_0;
  localparam logic [9:0] RDW = 10'b01111_1000_0;
  localparam logic [9:0] IMS = 10'b01111_1000_0;
  typedef struct {
    string tag;
    logic [9:0] v;
    logic [31:0] sc;
    logic chk_sc;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_stall = 0;
  exp_t sb[$];
  exp_t e;
  pipeline_control_if #(.CNT_W(CNT_W)) pif();
  pipeline_control #(.MD_CYCLES(4), .CNT_W(CNT_W)) dut(.clk(clk), .rst(rst), .p(pif.master));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    rst = 1'b0;
    pif.id_rsel1 = 5'd1;
    pif.id_rsel2 = 5'd2;
    pif.ex_rd = 5'd3;
    pif.ex_load = 1'b0;
    pif.ex_muldiv = 1'b0;
    pif.ex_redirect = 1'b0;
    pif.imem_ready = 1'b1;
    pif.dmem_req = 1'b0;
    pif.dmem_ready = 1'b1;
  endtask
  task automatic step(input string tag, input logic [9:0] v);
    exp_t x;
    x.tag = tag;
    x.v = v;
    x.sc = exp_stall;
    x.chk_sc = !rst;
    sb.push_back(x);
    if (rst) exp_stall = 0;
    else if (!v[9]) exp_stall++;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 32'({pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                        pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush, pif.md_done}), 32'(e.v));
      if (e.chk_sc) check({e.tag, "_cnt"}, pif.stall_cycles, e.sc);
    end
  end
  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; step("reset0", RST);
    rst = 1'b1; step("reset1", RST);
    idle(); step("run_default", DEF);
    idle(); pif.ex_load = 1'b1; pif.ex_rd = 5'd5; pif.id_rsel2 = 5'd5; step("load_use", LU);
    idle(); step("after_lu", DEF);
    idle(); pif.ex_load = 1'b1; pif.ex_rd = 5'd0; pif.id_rsel1 = 5'd0; pif.id_rsel2 = 5'd0; step("lu_x0", DEF);
    idle(); pif.ex_muldiv = 1'b1; step("md_start", MDS);
    for (int i = 0; i < 3; i++) begin idle(); step("md_wait", MDS); end
    idle(); step("md_done", MDD);
    idle(); step("after_md", DEF);
    idle(); pif.ex_muldiv = 1'b1; step("md2_start", MDS);
    idle(); step("md2_wait", MDS);
    for (int i = 0; i < 3; i++) begin idle(); pif.dmem_req = 1'b1; pif.dmem_ready = 1'b0; step("md2_dmem", DMS); end
    idle(); step("md2_wait_b", MDS);
    idle(); step("md2_wait_c", MDS);
    idle(); step("md2_done", MDD);
    idle(); pif.ex_redirect = 1'b1; pif.imem_ready = 1'b0; step("redir", RDR);
    idle(); pif.imem_ready = 1'b0; step("redir_wait0", RDW);
    idle(); pif.imem_ready = 1'b0; pif.ex_redirect = 1'b1; step("redir_ignore", RDW);
    idle(); pif.dmem_req = 1'b1; pif.dmem_ready = 1'b0; step("redir_dmem", DMS);
    idle(); step("redir_release", RDW);
    idle(); step("after_redir", DEF);
    idle(); pif.ex_redirect = 1'b1; step("redir_fast", RDR);
    idle(); step("after_fast", DEF);
    idle(); pif.ex_redirect = 1'b1; pif.ex_load = 1'b1; pif.ex_rd = 5'd7; pif.id_rsel1 = 5'd7; step("redir_vs_lu", RDR);
    idle(); step("after_prio", DEF);
    idle(); pif.imem_ready = 1'b0; step("imem_stall", IMS);
    idle(); pif.dmem_req = 1'b1; pif.dmem_ready = 1'b0; pif.ex_load = 1'b1; pif.ex_rd = 5'd2; step("dmem_vs_lu", DMS);
    idle(); pif.ex_muldiv = 1'b1; pif.ex_redirect = 1'b1; step("md_vs_redir", MDS);
    for (int i = 0; i < 3; i++) begin idle(); step("md3_wait", MDS); end
    idle(); step("md3_done", MDD);
    idle(); pif.ex_muldiv = 1'b1; step("md4_start", MDS);
    idle(); step("md4_wait", MDS);
    idle(); rst = 1'b1; step("md4_reset", RST);
    idle(); rst = 1'b1; step("md4_reset2", RST);
    for (int i = 0; i < 5; i++) begin idle(); step("post_reset", DEF); end
    @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
